throughput_run_controller: RTL

Sequences the stateful processor inside the high-throughput UART test harness. It sits between the byte replicator and the processor, and between the processor and the UART transmitter. Each run takes two command bytes from the host: a run length, then a seed byte. The block gates `processor_enable` for exactly the requested number of cycles plus the pipeline drain. It then returns one result byte over UART with a proper valid/ready handshake.

---
 rtl/throughput_test_pkg.sv | 28 ++
 rtl/run_length_counter.sv | 27 ++
 rtl/throughput_run_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/throughput_test_pkg.sv
// Shared definitions for the throughput test harness: run-controller state
// encoding, lane width and the run-length counter width helper.
package throughput_test_pkg;

    localparam int LANE_WIDTH = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_SEND    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        RUN     = ST_RUN,
        DRAIN   = ST_DRAIN,
        CAPTURE = ST_CAPTURE,
        SEND    = ST_SEND
    } run_state_t;

    // One extra bit so a zero length byte can stand for 2**count_width.
    function automatic int counter_width(input int count_width);
        return count_width + 1;
    endfunction

endpackage

// File: rtl/run_length_counter.sv
// Loadable down-counter shared by the RUN and DRAIN phases; saturates at zero.
module run_length_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             at_one
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign at_one = (count == WIDTH'(1));

endmodule

// File: rtl/throughput_run_controller.sv
// Gates the processor for a host-requested run length plus pipeline drain,
// then returns the processor result byte over a valid/ready handshake.
module throughput_run_controller
    import throughput_test_pkg::*;
#(
    parameter int REPLICATION_FACTOR = 12,
    parameter int PROCESSOR_LATENCY  = 2,
    parameter int COUNT_WIDTH        = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [LANE_WIDTH*REPLICATION_FACTOR-1:0] in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  processor_enable,
    output logic [LANE_WIDTH*REPLICATION_FACTOR-1:0] processor_data_in,
    input  logic [LANE_WIDTH-1:0]                 processor_data_out,
    output logic [LANE_WIDTH-1:0]                 out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy
);

    localparam int  CW       = counter_width(COUNT_WIDTH);
    localparam bit  NO_DRAIN = (PROCESSOR_LATENCY == 0);

    run_state_t    state;
    logic [CW-1:0] length_q;
    logic [CW-1:0] length_next;
    logic          ctr_load;
    logic [CW-1:0] ctr_value;
    logic          ctr_dec;
    logic          ctr_at_one;

    // A zero length byte means the full 2**COUNT_WIDTH cycles.
    assign length_next = (in_data[COUNT_WIDTH-1:0] == '0) ? CW'(1 << COUNT_WIDTH)
                                                         : {1'b0, in_data[COUNT_WIDTH-1:0]};

    assign in_ready = reset && (state == IDLE || state == LOAD);
    assign busy     = (state != IDLE);

    always_comb begin
        ctr_load  = 1'b0;
        ctr_value = length_q;
        ctr_dec   = (state == RUN) || (state == DRAIN);
        if (state == LOAD && in_valid) begin
            ctr_load = 1'b1;
        end else if (state == RUN && ctr_at_one && !NO_DRAIN) begin
            ctr_load  = 1'b1;
            ctr_value = CW'(PROCESSOR_LATENCY);
        end
    end

    run_length_counter #(.WIDTH(CW)) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (ctr_load),
        .load_value (ctr_value),
        .decrement  (ctr_dec),
        .at_one     (ctr_at_one)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            length_q          <= '0;
            processor_enable  <= 1'b0;
            processor_data_in <= '0;
            out_data          <= '0;
            out_valid         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        length_q <= length_next;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        processor_data_in <= in_data;
                        processor_enable  <= 1'b1;
                        state             <= RUN;
                    end
                end
                RUN: begin
                    if (ctr_at_one) begin
                        if (NO_DRAIN) begin
                            processor_enable <= 1'b0;
                            state            <= CAPTURE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (ctr_at_one) begin
                        processor_enable <= 1'b0;
                        state            <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_data  <= processor_data_out;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
